// File: rtl/inv_factorial_if.sv
`default_nettype none
// ============================================================================
//  Module   : inv_factorial_if
//  Purpose  : Request/result bundle for the inverse-factorial evaluator.
//             The master drives a start request with a 32-bit operand; the
//             slave reports busy, a one-cycle done pulse and the result.
//  Signals  : start  - request to evaluate value (master -> slave)
//             value  - 32-bit unsigned operand  (master -> slave)
//             busy   - evaluation in progress   (slave -> master)
//             done   - one-cycle result strobe  (slave -> master)
//             n      - largest k in 1..12 with k! <= value, 0 for value 0
//             exact  - n! equals value exactly
//  Revision : 1.0 - initial release
// ============================================================================
interface inv_factorial_if;
   logic        start;
   logic [31:0] value;
   logic        busy;
   logic        done;
   logic [3:0]  n;
   logic        exact;

   modport master (
      output start,
      output value,
      input  busy,
      input  done,
      input  n,
      input  exact
   );

   modport slave (
      input  start,
      input  value,
      output busy,
      output done,
      output n,
      output exact
   );
endinterface : inv_factorial_if
`default_nettype wire

// File: rtl/inv_factorial.sv
`default_nettype none
// ============================================================================
//  Module   : inv_factorial
//  Purpose  : Iterative inverse factorial. Given a 32-bit operand, finds the
//             largest k in 1..12 whose factorial does not exceed it and flags
//             whether the match is exact. One multiply step per clock.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - inv_factorial_if.slave (start/value in,
//                    busy/done/n/exact out)
//  Revision : 1.0 - initial release
// ============================================================================
module inv_factorial (
   input  wire logic        clk,
   input  wire logic        rst,
   inv_factorial_if.slave   bus
);

   // 12! is the largest factorial representable in 32 bits, so the search
   // never needs to go beyond this index.
   localparam logic [3:0] C_I_MAX = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] value_q;   // operand latched on acceptance
   logic [31:0] acc_q;     // i_q! while searching
   logic [3:0]  i_q;       // current candidate index
   logic        busy_q;
   logic        done_q;
   logic [3:0]  n_q;
   logic        exact_q;

   // Candidate next factorial. Kept at 36 bits so that a product past the
   // 32-bit range still compares as "greater than value" instead of wrapping.
   logic [35:0] nxt_d;
   logic        stop_d;

   assign nxt_d  = {4'd0, acc_q} * {32'd0, i_q + 4'd1};
   assign stop_d = (i_q == C_I_MAX) || (nxt_d > {4'd0, value_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         value_q <= 32'd0;
         acc_q   <= 32'd1;
         i_q     <= 4'd1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         n_q     <= 4'd0;
         exact_q <= 1'b0;
      end else begin
         // done is a strobe; only the finishing branch raises it.
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  value_q <= bus.value;
                  acc_q   <= 32'd1;
                  i_q     <= 4'd1;
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
               end
            end

            S_CALC: begin
               if (value_q == 32'd0) begin
                  n_q     <= 4'd0;
                  exact_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (stop_d) begin
                  // acc_q holds i_q!, the largest factorial not above value.
                  n_q     <= i_q;
                  exact_q <= (acc_q == value_q);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  // stop_d is false, so nxt_d fits in 32 bits here.
                  acc_q   <= nxt_d[31:0];
                  i_q     <= i_q + 4'd1;
               end
            end

            S_DONE: begin
               // start is deliberately ignored here; a new request is only
               // taken once back in IDLE.
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.n     = n_q;
   assign bus.exact = exact_q;

endmodule : inv_factorial
`default_nettype wire

// File: tb/tb_inv_factorial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_factorial
//  Purpose  : Self-checking bench for inv_factorial. A transaction-level
//             model predicts busy/done/n/exact every cycle; directed runs
//             pin literal results and latencies, then random traffic with
//             occasional resets and continuous start streams follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inv_factorial;

   logic clk;
   logic rst;
   int   tests;
   int   errors;

   inv_factorial_if bus ();

   inv_factorial dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Reference: plain search over factorials with wide arithmetic.
   // ---------------------------------------------------------------------
   task automatic ref_eval(input logic [31:0] v, output logic [3:0] rn, output logic re);
      longint f;
      int     k;
      if (v == 32'd0) begin
         rn = 4'd0;
         re = 1'b0;
      end else begin
         f = 1;
         k = 1;
         while (k < 12 && f * (k + 1) <= longint'(v)) begin
            f = f * (k + 1);
            k++;
         end
         rn = 4'(k);
         re = (f == longint'(v));
      end
   endtask

   function automatic longint fact(input int k);
      longint f = 1;
      for (int j = 2; j <= k; j++) f = f * j;
      return f;
   endfunction

   function automatic logic [31:0] pick();
      int k;
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: begin k = $urandom_range(1, 12); return 32'(fact(k)); end
         2: begin
            k = $urandom_range(1, 12);
            return ($urandom_range(0, 1) != 0) ? 32'(fact(k) + 1) : 32'(fact(k) - 1);
         end
         3: return $urandom;
         default: return 32'($urandom_range(0, 100000));
      endcase
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Cycle-level expectation: an accepted request produces done after
   // max(n,1) cycles, followed by one DONE cycle in which start is ignored.
   // ---------------------------------------------------------------------
   logic       m_busy, m_done, m_exact, p_e;
   logic [3:0] m_n, p_n;
   int         m_rem;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_n     = 4'd0;
         m_exact = 1'b0;
         m_rem   = 0;
      end else if (m_rem != 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_busy  = 1'b0;
            m_done  = 1'b1;
            m_n     = p_n;
            m_exact = p_e;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (bus.start) begin
         ref_eval(bus.value, p_n, p_e);
         m_rem  = (p_n == 4'd0) ? 1 : int'(p_n);
         m_busy = 1'b1;
      end
   end

   always @(negedge clk) begin
      #2;
      chk("busy",  bus.busy,  m_busy);
      chk("done",  bus.done,  m_done);
      chk("n",     bus.n,     m_n);
      chk("exact", bus.exact, m_exact);
   end

   // ---------------------------------------------------------------------
   // Directed helpers (inputs driven 1 time unit after the falling edge).
   // ---------------------------------------------------------------------
   task automatic wait_idle();
      int k = 0;
      while ((bus.busy || bus.done) && k < 40) begin
         @(negedge clk); #1;
         k++;
      end
      if (k >= 40) chk("idle_timeout", 1, 0);
   endtask

   task automatic run_one(input logic [31:0] v, input int en, input int ee,
                          input int el, input bit hold);
      int k;
      int bc;
      wait_idle();
      bus.start = 1'b1;
      bus.value = v;
      @(negedge clk); #1;
      if (hold) bus.value = 32'd720;
      else      bus.start = 1'b0;
      k  = 0;
      bc = 0;
      while (!bus.done && k < 40) begin
         if (bus.busy) bc++;
         @(negedge clk); #1;
         k++;
      end
      bus.start = 1'b0;
      chk("done_seen",  bus.done, 1);
      chk("latency",    k, el);
      chk("busy_count", bc, el);
      chk("res_n",      bus.n, en);
      chk("res_exact",  bus.exact, ee);
   endtask

   initial begin
      int k;
      int gap;
      tests     = 0;
      errors    = 0;
      bus.start = 1'b0;
      bus.value = 32'd0;
      rst       = 1'b1;
      #1;
      chk("rst_busy",  bus.busy,  0);
      chk("rst_done",  bus.done,  0);
      chk("rst_n",     bus.n,     0);
      chk("rst_exact", bus.exact, 0);
      // start high during reset and at release must not launch anything early
      bus.start = 1'b1;
      bus.value = 32'd120;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      rst = 1'b0;
      @(negedge clk); #1;

      run_one(32'd120,       5, 1, 5, 1'b0);
      run_one(32'd121,       5, 0, 5, 1'b0);
      run_one(32'd0,         0, 0, 1, 1'b0);
      run_one(32'd1,         1, 1, 1, 1'b0);
      run_one(32'd479001600, 12, 1, 12, 1'b0);
      run_one(32'hFFFFFFFF,  12, 0, 12, 1'b0);
      run_one(32'd24,        4, 1, 4, 1'b1);
      repeat (6) @(negedge clk);
      #1;

      // Reset in the middle of an evaluation.
      wait_idle();
      bus.start = 1'b1;
      bus.value = 32'd5040;
      @(negedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_busy",  bus.busy,  0);
      chk("abort_done",  bus.done,  0);
      chk("abort_n",     bus.n,     0);
      chk("abort_exact", bus.exact, 0);
      @(negedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); #1;
         chk("abort_no_done", bus.done, 0);
      end
      run_one(32'd6, 3, 1, 3, 1'b0);

      // Continuous start: done pulses spaced by DONE + IDLE + latency.
      wait_idle();
      bus.start = 1'b1;
      bus.value = 32'd2;
      k = 0;
      while (!bus.done && k < 40) begin @(negedge clk); #1; k++; end
      chk("b2b_first", bus.done, 1);
      gap = 0;
      @(negedge clk); #1;
      chk("b2b_pulse", bus.done, 0);
      gap = 1;
      while (!bus.done && gap < 40) begin @(negedge clk); #1; gap++; end
      chk("b2b_gap", gap, 4);
      bus.start = 1'b0;

      // Random traffic with sporadic resets.
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk); #1;
         rst       = ($urandom_range(0, 299) == 0);
         bus.start = ($urandom_range(0, 2) != 0);
         bus.value = pick();
      end
      @(negedge clk); #1;
      rst = 1'b0;
      // Held start with a fresh operand every cycle.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk); #1;
         bus.start = 1'b1;
         bus.value = pick();
      end
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule : tb_inv_factorial
`default_nettype wire
